// File: rtl/image_ram_writer.sv
// Streams pixel bytes from a valid/ready source into a flat image RAM,
// laying out IMAGES consecutive images of PIXELS bytes each.
module image_ram_writer #(
  parameter int PIXELS = 784,
  parameter int IMAGES = 40,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              img_done,
  output logic [5:0]        img_idx,
  output logic              busy,
  output logic              all_done,
  output logic              err
);

  localparam int PW = (PIXELS > 1) ? $clog2(PIXELS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [PW-1:0]     pix;
  logic [ADDR_W-1:0] base;
  logic              go;
  logic              xfer;
  logic              pix_last;
  logic              img_last;

  assign go       = start && (state != WRITE);
  assign xfer     = in_valid && (state == WRITE) && !abort;
  assign pix_last = (pix == PW'(PIXELS - 1));
  assign img_last = (img_idx == 6'(IMAGES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    all_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = WRITE;
      end
      WRITE: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (abort)
          state_nx = IDLE;
        else if (xfer && pix_last && img_last)
          state_nx = DONE;
      end
      DONE: begin
        all_done = 1'b1;
        if (start) state_nx = WRITE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Address is a running base plus pixel offset, so no multiplier is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix      <= '0;
      base     <= '0;
      img_idx  <= '0;
      err      <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      img_done <= 1'b0;
    end else begin
      ram_we   <= xfer;
      img_done <= xfer && pix_last;
      if (go) begin
        pix     <= '0;
        base    <= '0;
        img_idx <= '0;
        err     <= 1'b0;
      end else if (xfer) begin
        ram_addr <= base + ADDR_W'(pix);
        ram_din  <= in_data;
        if (in_last != pix_last) err <= 1'b1;
        if (pix_last) begin
          pix     <= '0;
          base    <= base + ADDR_W'(PIXELS);
          img_idx <= img_idx + 6'd1;
        end else begin
          pix <= pix + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_image_ram_writer.sv
// Randomized bench for image_ram_writer; the model treats a load as one
// linear byte stream whose n-th accepted byte lands at address n.
module tb_image_ram_writer;

  localparam int P  = 784;
  localparam int N  = 40;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din;
  logic          img_done;
  logic [5:0]    img_idx;
  logic          busy;
  logic          all_done;
  logic          err;

  image_ram_writer #(.PIXELS(P), .IMAGES(N), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .img_done (img_done),
    .img_idx  (img_idx),
    .busy     (busy),
    .all_done (all_done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        done;
    logic [31:0] cyc;
  } wr_t;

  wr_t got[$];
  wr_t exp[$];
  int  cyc = 0;
  int  ndone = 0;
  int  k = 0;
  bit  mwrite = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_we)
      got.push_back('{32'(ram_addr), 32'(ram_din), img_done, 32'(cyc)});
    if (img_done) ndone++;
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (!mwrite) begin
      k = 0;
      mwrite = 1;
      got.delete();
      exp.delete();
      ndone = 0;
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    mwrite = 0;
    @(negedge clk); #1;
  endtask

  task automatic drive(input int n, input int pct, input int bad_k,
                       input bit pixdata);
    int sent;
    int budget;
    bit v;
    sent = 0;
    budget = n * 4 + 100;
    while (sent < n && budget > 0) begin
      v = ($urandom_range(99) < pct);
      in_valid = v;
      in_data = pixdata ? 8'(k % P) : 8'($urandom);
      in_last = ((k % P) == P - 1) ^ (k == bad_k);
      @(posedge clk); #1;
      budget--;
      if (v && mwrite) begin
        exp.push_back('{32'(k), 32'(in_data), (k % P) == P - 1, 32'(cyc)});
        k++;
        sent++;
        if (k == P * N) mwrite = 0;
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({in_ready, ram_we, ram_addr, ram_din, img_done, img_idx,
         busy, all_done, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b addr=%0d busy=%b err=%b exp 0",
               ram_we, ram_addr, busy, err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_image();
    int bad;
    do_start();
    checks++;
    if ({busy, in_ready, err, img_idx} !== {1'b1, 1'b1, 1'b0, 6'd0}) begin
      errors++;
      $display("FAIL start_state got busy=%b rdy=%b err=%b idx=%0d exp 1 1 0 0",
               busy, in_ready, err, img_idx);
    end
    drive(P, 100, -1, 1);
    @(negedge clk); #1;
    checks++;
    if (got.size() !== P) begin
      errors++;
      $display("FAIL img1_count got %0d exp %0d", got.size(), P);
    end
    bad = 0;
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (got[i] !== exp[i] || got[i].cyc !== got[0].cyc + i) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL img1_stream got %0d bad writes exp 0", bad);
    end
    checks++;
    if (got.size() == 0 || got[got.size()-1].addr !== 783 ||
        got[got.size()-1].done !== 1'b1 || ndone !== 1) begin
      errors++;
      $display("FAIL img1_done got ndone=%0d exp 1 at addr 783", ndone);
    end
    checks++;
    if ({img_idx, err} !== {6'd1, 1'b0}) begin
      errors++;
      $display("FAIL img1_idx got idx=%0d err=%b exp 1 0", img_idx, err);
    end
    do_abort();
  endtask

  task automatic test_gaps();
    int bad;
    do_start();
    drive(2 * P, 100, -1, 0);
    drive(P, 50, -1, 0);
    @(negedge clk); #1;
    checks++;
    if (got.size() !== exp.size() || exp.size() !== 3 * P) begin
      errors++;
      $display("FAIL gaps_count got %0d exp %0d", got.size(), 3 * P);
    end
    bad = 0;
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (got[i] !== exp[i]) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL gaps_stream got %0d bad writes exp 0", bad);
    end
    checks++;
    if (got.size() < 3 * P || got[2*P].addr !== 1568 ||
        got[3*P-1].addr !== 2351) begin
      errors++;
      $display("FAIL gaps_range got size %0d exp addr 1568..2351", got.size());
    end
    do_abort();
  endtask

  task automatic test_framing();
    int bad;
    do_start();
    drive(101, 100, 100, 0);
    @(negedge clk); #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL frame_err got %b exp 1", err);
    end
    drive(2 * P - 101, 100, 100, 0);
    @(negedge clk); #1;
    checks++;
    if (err !== 1'b1 || ndone !== 2) begin
      errors++;
      $display("FAIL frame_sticky got err=%b ndone=%0d exp 1 2", err, ndone);
    end
    bad = 0;
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (got[i] !== exp[i]) bad++;
    checks++;
    if (bad !== 0 || got.size() !== 2 * P || got[P].addr !== 784) begin
      errors++;
      $display("FAIL frame_stream got %0d bad size %0d exp 0 %0d",
               bad, got.size(), 2 * P);
    end
    do_abort();
  endtask

  task automatic test_abort();
    int bad;
    do_start();
    drive(P + 300, 100, -1, 0);
    abort = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    in_valid = 1'b0;
    mwrite = 0;
    checks++;
    if ({busy, in_ready} !== 2'b00) begin
      errors++;
      $display("FAIL abort_state got busy=%b rdy=%b exp 0 0", busy, in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (got[i] !== exp[i]) bad++;
    checks++;
    if (bad !== 0 || got.size() !== 1084 || got[got.size()-1].addr !== 1083) begin
      errors++;
      $display("FAIL abort_stream got size %0d bad %0d exp size 1084 last 1083",
               got.size(), bad);
    end
    do_start();
    drive(1, 100, -1, 0);
    @(negedge clk); #1;
    checks++;
    if (got.size() !== 1 || got[0].addr !== 0) begin
      errors++;
      $display("FAIL abort_restart got size %0d exp 1 write at addr 0",
               got.size());
    end
    do_abort();
  endtask

  task automatic test_start_ignored_and_reset();
    int bad;
    do_start();
    drive(200, 100, -1, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({busy, img_idx} !== {1'b1, 6'd0}) begin
      errors++;
      $display("FAIL start_ignored got busy=%b idx=%0d exp 1 0", busy, img_idx);
    end
    drive(600, 100, -1, 0);
    #2;
    checks++;
    if (ram_we !== 1'b1) begin
      errors++;
      $display("FAIL pending_write got we=%b exp 1", ram_we);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, ram_we, ram_addr, ram_din, img_done, img_idx,
         busy, all_done, err} !== '0) begin
      errors++;
      $display("FAIL async_reset got we=%b addr=%0d idx=%0d busy=%b exp 0",
               ram_we, ram_addr, img_idx, busy);
    end
    @(negedge clk); #1;
    rst = 1'b0;
    mwrite = 0;
    bad = 0;
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (got[i] !== exp[i]) bad++;
    checks++;
    if (bad !== 0 || got.size() !== 799) begin
      errors++;
      $display("FAIL ignore_stream got size %0d bad %0d exp 799 0",
               got.size(), bad);
    end
    do_start();
    drive(5, 100, -1, 0);
    @(negedge clk); #1;
    bad = 0;
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (got[i] !== exp[i]) bad++;
    checks++;
    if (bad !== 0 || got.size() !== 5 || got[0].addr !== 0) begin
      errors++;
      $display("FAIL reset_restart got size %0d bad %0d exp 5 0", got.size(), bad);
    end
    do_abort();
  endtask

  task automatic test_full_load();
    int bad;
    do_start();
    drive(P * N, 100, -1, 0);
    @(negedge clk); #1;
    bad = 0;
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (got[i] !== exp[i]) bad++;
    checks++;
    if (bad !== 0 || got.size() !== 31360 ||
        got[got.size()-1].addr !== 31359) begin
      errors++;
      $display("FAIL full_stream got size %0d bad %0d exp 31360 0",
               got.size(), bad);
    end
    checks++;
    if ({all_done, in_ready, busy, img_idx, err} !==
        {1'b1, 1'b0, 1'b0, 6'd40, 1'b0} || ndone !== N) begin
      errors++;
      $display("FAIL full_state got ad=%b rdy=%b idx=%0d ndone=%0d exp 1 0 40 40",
               all_done, in_ready, img_idx, ndone);
    end
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (got.size() !== 31360 || all_done !== 1'b1) begin
      errors++;
      $display("FAIL done_hold got size %0d ad=%b exp 31360 1",
               got.size(), all_done);
    end
    do_start();
    checks++;
    if ({all_done, busy, img_idx} !== {1'b0, 1'b1, 6'd0}) begin
      errors++;
      $display("FAIL done_restart got ad=%b busy=%b idx=%0d exp 0 1 0",
               all_done, busy, img_idx);
    end
    do_abort();
  endtask

  initial begin
    test_reset();
    test_single_image();
    test_gaps();
    test_framing();
    test_abort();
    test_start_ignored_and_reset();
    test_full_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_ram_writer.md
IMAGE_RAM_WRITER -- requirements
Module: image_ram_writer

Interface
REQ-001 The block SHALL have parameter PIXELS, default 784, giving bytes per image (one input vector).
REQ-002 The block SHALL have parameter IMAGES, default 40, giving images per load.
REQ-003 The block SHALL have parameter ADDR_W, default 15, giving the RAM address width.
REQ-004 The block SHALL have port clk, input, 1, the clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1, a single-cycle load request.
REQ-007 The block SHALL have port abort, input, 1, a synchronous load cancel.
REQ-008 The block SHALL have port in_valid, input, 1, meaning the source holds a pixel byte.
REQ-009 The block SHALL have port in_data, input, 8, the pixel byte.
REQ-010 The block SHALL have port in_last, input, 1, the source's end-of-image marker.
REQ-011 The block SHALL have port in_ready, output, 1, meaning the block accepts a byte this cycle.
REQ-012 The block SHALL have port ram_we, output, 1, the RAM write enable.
REQ-013 The block SHALL have port ram_addr, output, ADDR_W, the RAM write address.
REQ-014 The block SHALL have port ram_din, output, 8, the RAM write data.
REQ-015 The block SHALL have port img_done, output, 1, a one-cycle pulse when an image completes.
REQ-016 The block SHALL have port img_idx, output, 6, the index of the image currently being written.
REQ-017 The block SHALL have port busy, output, 1, high in state WRITE.
REQ-018 The block SHALL have port all_done, output, 1, high in state DONE.
REQ-019 The block SHALL have port err, output, 1, a sticky framing-error flag.

Function
REQ-020 The block SHALL implement an FSM with states IDLE, WRITE and DONE.
REQ-021 In IDLE and DONE, start SHALL move the FSM to WRITE and clear the pixel count, img_idx, the address base, err and all_done; start SHALL be ignored in WRITE.
REQ-022 in_ready SHALL equal (state==WRITE); a transfer occurs on a cycle where in_valid and in_ready are both high.
REQ-023 On each transfer, the next cycle SHALL present ram_we=1, ram_addr=base+pix and ram_din=in_data (registered outputs, 1-cycle latency); otherwise ram_we SHALL be 0.
REQ-024 The address SHALL equal img_idx*PIXELS+pix, formed by an incrementing base register (base+=PIXELS per image) and not by a multiplier; the maximum address is 31359.
REQ-025 pix SHALL increment on every transfer; at pix==PIXELS-1 it SHALL wrap to 0, base SHALL add PIXELS and img_idx SHALL increment.
REQ-026 img_done SHALL pulse for 1 cycle, coincident with the ram_we of an image's last byte.
REQ-027 A transfer with pix==PIXELS-1 and img_idx==IMAGES-1 SHALL move the FSM to DONE; in_ready SHALL be 0 from the next cycle.
REQ-028 The block SHALL set err (sticky) on a transfer where in_last != (pix==PIXELS-1).
REQ-029 Framing errors SHALL NOT alter counting; the pixel count alone governs address and completion.
REQ-030 abort in WRITE SHALL return the FSM to IDLE next cycle; no transfer SHALL be accepted in the abort cycle.
REQ-031 A write already registered before an abort SHALL still complete.
REQ-032 abort SHALL have priority over a simultaneous transfer.
REQ-033 In DONE, img_idx SHALL hold IMAGES; all_done SHALL remain 1 until start or rst.
REQ-034 in_valid low SHALL stall the block with no state change; the block SHALL impose no bubble between back-to-back transfers.

Reset
REQ-035 rst SHALL force IDLE, pix=0, base=0, img_idx=0, ram_we=0, ram_addr=0, ram_din=0, img_done=0, busy=0, all_done=0, err=0 and in_ready=0, immediately and independent of clk.
REQ-036 rst during WRITE SHALL drop any pending write; the next start SHALL restart from address 0.

Verification
REQ-037 Bench: start, then 784 bytes with in_valid always 1, data=pix[7:0], in_last on byte 783 -> writes to addr 0..783 on consecutive cycles, img_done once with addr 783, img_idx=1, err=0.
REQ-038 Bench: full load of 40x784 bytes -> last write at addr 31359, all_done=1, in_ready=0, 31360 total writes.
REQ-039 Bench: random in_valid gaps (50%) on image 2 -> addresses 1568..2351 contiguous, with no write on idle cycles.
REQ-040 Bench: in_last asserted on byte 100 of image 0 -> err=1 sticky, image still ends at byte 783, next image starts at addr 784.
REQ-041 Bench: abort after 300 bytes of image 1 -> last write addr 1083, busy=0, and a later start writes addr 0 first.
REQ-042 Bench: rst asserted mid-cycle during WRITE -> all outputs 0 asynchronously; start pulsed during WRITE -> ignored, counters unchanged.
